timer_periph: RTL and testbench

//  Memory-mapped programmable down-counting timer on the CPU peripheral port.

---
 rtl/timer_periph.sv | 148 ++++++++++++++
 tb/tb_timer_periph.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_periph.sv
// rtl/timer_periph.sv - memory-mapped down-counting timer with prescaler, auto-reload and level interrupt
module timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] presc_cnt_q, presc_cnt_d;

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_preset, wr_status, wr_presc;
    logic       start, stop, tick;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];

    always_comb begin
        hit       = (addr_i[31:5] == BASE_ADDR[31:5]);
        off       = addr_i[4:2];
        wr_ctrl   = we_i && hit && (off == 3'd0);
        wr_preset = we_i && hit && (off == 3'd1);
        wr_status = we_i && hit && (off == 3'd3);
        wr_presc  = we_i && hit && (off == 3'd4);
        start     = wr_ctrl && wdata_i[0] && !ctrl_q[0];
        stop      = wr_ctrl && !wdata_i[0];
        tick      = (presc_cnt_q == presc_q);
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        preset_d    = preset_q;
        count_d     = count_q;
        exp_d       = exp_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;

        if (wr_ctrl)
            ctrl_d = wdata_i[2:0];
        if (wr_preset)
            preset_d = wdata_i;
        if (wr_presc)
            presc_d = wdata_i[15:0];
        if (wr_status && wdata_i[0])
            exp_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d     = preset_q;
                presc_cnt_d = 16'd0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (tick) begin
                    presc_cnt_d = 16'd0;
                    // A preset of 0 expires on the first tick, same as a preset of 1
                    if (count_q <= 32'd1) begin
                        count_d = 32'd0;
                        state_d = S_EXPIRE;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + 16'd1;
                end
            end
            S_EXPIRE: begin
                // Setting EXP overrides a same-cycle W1C clear
                exp_d = 1'b1;
                if (ctrl_q[2]) begin
                    state_d = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stopping freezes the count where it is; EXP set in EXPIRE still stands
        if (stop) begin
            state_d     = S_IDLE;
            count_d     = count_q;
            presc_cnt_d = presc_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= 3'd0;
            preset_q    <= 32'd0;
            count_q     <= 32'd0;
            exp_q       <= 1'b0;
            presc_q     <= 16'd0;
            presc_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            exp_q       <= exp_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        if (hit) begin
            case (off)
                3'd0:    rdata_o = {29'd0, ctrl_q};
                3'd1:    rdata_o = preset_q;
                3'd2:    rdata_o = count_q;
                3'd3:    rdata_o = {31'd0, exp_q};
                3'd4:    rdata_o = {16'd0, presc_q};
                default: rdata_o = 32'd0;
            endcase
        end
    end

    assign irq_o = exp_q & ctrl_q[1];

endmodule

// File: tb/tb_timer_periph.sv
// tb/tb_timer_periph.sv - self-checking bench for timer_periph against an arithmetic timing model
module tb_timer_periph;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [31:0] rdata_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    timer_periph #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .we_i    (we_i),
        .rdata_o (rdata_o),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        @(posedge clk);
        #1;
        we_i    = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        wr_addr(BASE + 32'(off), d);
    endtask

    task automatic rd_addr(input logic [31:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = rdata_o;
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        rd_addr(BASE + 32'(off), d);
    endtask

    // COUNT and irq are predicted from elapsed edges alone: after the enabling
    // edge E0, COUNT=N at E1 and drops once every P+1 edges; EXP rises at 2+max(N,1)*(P+1).
    task automatic oneshot(input int n, input int p);
        logic [31:0] d;
        int tex, cnt;
        tex = 2 + ((n < 1) ? 1 : n) * (p + 1);
        wr(4, 32'(n));
        wr(16, 32'(p));
        wr(0, 32'h3);
        for (int t = 1; t <= tex + 1; t++) begin
            tick();
            cnt = n - (t - 1) / (p + 1);
            if (cnt < 0) cnt = 0;
            rd(8, d);
            check($sformatf("os_count n=%0d p=%0d t=%0d", n, p, t), d, 32'(cnt));
            rd(0, d);
            check($sformatf("os_en n=%0d p=%0d t=%0d", n, p, t), {31'd0, d[0]}, {31'd0, (t < tex)});
            check($sformatf("os_irq n=%0d p=%0d t=%0d", n, p, t), {31'd0, irq_o}, {31'd0, (t >= tex)});
        end
        rd(0, d);
        check("os_ctrl_after", d, 32'h2);
        wr(12, 32'h1);
        check("os_irq_cleared", {31'd0, irq_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        int n, p, first, period;
        bit m, clr;

        rst = 1'b1; addr_i = 32'd0; wdata_i = 32'd0; we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // T1 reset state
        for (int o = 0; o < 8; o++) begin
            rd(o * 4, d);
            check($sformatf("reset_rd off=%0d", o * 4), d, 32'd0);
        end
        check("reset_irq", {31'd0, irq_o}, 32'd0);
        wr(8, 32'd5);
        rd(8, d);
        check("count_ro", d, 32'd0);
        wr(16, 32'hFFFF_0002);
        rd(16, d);
        check("presc_upper_zero", d, 32'h0000_0002);
        wr(0, 32'hFFFF_FFF8);
        rd(0, d);
        check("ctrl_upper_zero", d, 32'd0);

        // T2 directed one-shot, then randomized one-shots
        oneshot(3, 0);
        oneshot(0, 1);
        for (int k = 0; k < 5; k++)
            oneshot(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));

        // T3 auto-reload with W1C clears; T5 clear lands on a set edge
        n = 2; p = 3;
        first  = 2 + n * (p + 1);
        period = n * (p + 1) + 2;
        wr(4, 32'(n));
        wr(16, 32'(p));
        wr(0, 32'h7);
        m = 1'b0;
        for (int t = 1; t <= first + 2 * period + 1; t++) begin
            clr = (t == first + 2) || (t == first + period + 5) || (t == first + 2 * period);
            if (clr) begin
                addr_i = BASE + 32'd12; wdata_i = 32'h1; we_i = 1'b1;
            end
            tick();
            we_i = 1'b0;
            if (t >= first && (t - first) % period == 0) m = 1'b1;
            else if (clr) m = 1'b0;
            check($sformatf("auto_irq t=%0d", t), {31'd0, irq_o}, {31'd0, m});
        end
        wr(0, 32'h0);
        wr(12, 32'h1);
        check("auto_stop_irq", {31'd0, irq_o}, 32'd0);

        // T4 stop and hold, then restart reloads
        wr(4, 32'd8);
        wr(16, 32'd0);
        wr(0, 32'h3);
        repeat (4) tick();
        rd(8, d);
        check("hold_pre", d, 32'd5);
        wr(0, 32'h0);
        rd(8, d);
        check("hold_at_stop", d, 32'd5);
        repeat (3) tick();
        rd(8, d);
        check("hold_later", d, 32'd5);
        check("hold_irq", {31'd0, irq_o}, 32'd0);
        wr(0, 32'h3);
        tick();
        rd(8, d);
        check("restart_reload", d, 32'd8);
        wr(0, 32'h0);

        // T6 decode: out-of-window and unmapped writes change nothing
        wr(32, 32'hFFFF_FFFF);
        wr(20, 32'hFFFF_FFFF);
        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            if (a[31:5] == BASE[31:5]) a[31] = ~a[31];
            wr_addr(a, 32'h7);
            rd_addr(a, d);
            check($sformatf("miss_rd a=%h", a), d, 32'd0);
        end
        rd(32, d); check("rd_base_plus_20", d, 32'd0);
        rd(20, d); check("rd_off_14", d, 32'd0);
        rd(0, d);  check("decode_ctrl", d, 32'd0);
        rd(4, d);  check("decode_preset", d, 32'd8);
        rd(8, d);  check("decode_count", d, 32'd8);
        rd(12, d); check("decode_status", d, 32'd0);
        rd(16, d); check("decode_presc", d, 32'd0);

        // reset during RUN
        wr(0, 32'h3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(8, d);  check("rst_run_count", d, 32'd0);
        rd(0, d);  check("rst_run_ctrl", d, 32'd0);
        rd(4, d);  check("rst_run_preset", d, 32'd0);
        check("rst_run_irq", {31'd0, irq_o}, 32'd0);
        repeat (3) tick();
        rd(8, d);  check("rst_run_idle_count", d, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
